common_rr_arbiter: RTL and testbench
====================================

Name: common_rr_arbiter

Overview:
- Round-robin lock arbiter that shares one resource among N requesters.
- A requester holds the grant across a multi-cycle transaction until it releases it.
- Sits in front of any shared datapath resource (bus port, buffer, config register file) in blocks built on common_pkg.
- Provides one-hot grant, encoded owner ID and busy status.

Parameters:
- N, 4, number of requesters (2..16).
- IDW, $clog2(N), owner ID width (derived; do not override).
- MAX_HOLD, 64, maximum consecutive owned cycles before forced revoke (timeout build only; must be >= 2).

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N  per-requester request, level; held while wanting or owning the resource.
- rel  input  N  per-requester release pulse; only the bit of the current owner is honoured.
- gnt  output  N  one-hot grant, registered.
- gnt_id  output  IDW  index of the current owner; valid while busy.
- busy  output  1  resource owned (gnt != 0).
- timeout_err  output  1  one-cycle pulse on forced revoke (timeout build only).

Behaviour:
- Reset values: gnt=0, gnt_id=0, busy=0, timeout_err=0, state=ARB_IDLE, rr pointer=N-1, so requester 0 has first priority.
- Reset asserted mid-ownership drops gnt immediately, asynchronously.
- FSM states: ARB_IDLE and ARB_OWNED.
- ARB_IDLE:
  - If req != 0 at edge t, the winner is the first set bit searching upward from (pointer+1) mod N, wrapping.
  - At t+1: gnt=onehot(winner), gnt_id=winner, busy=1, pointer=winner, state=ARB_OWNED.
  - Grant latency is 1 cycle.
- ARB_OWNED, exit conditions (any one):
  - rel[gnt_id]=1.
  - req[gnt_id]=0 (implicit release).
  - Timeout (see Optional Feature).
- On exit: gnt=0 and busy=0 next cycle; state returns to ARB_IDLE.
- Exactly one dead cycle separates consecutive owners.
  - Earliest next grant is 2 cycles after the release edge.
- rel bits of non-owners are ignored in all states. rel in ARB_IDLE is ignored.
- req changes of non-owners during ARB_OWNED have no effect. Arbitration happens only in ARB_IDLE.
- Simultaneous rel[owner] and req[owner]=1: release wins. The owner may be re-granted only by fair rotation.
  - The pointer has moved to the owner, so the owner has lowest priority next round.
- The same requester can own consecutively only if no other req is set in the arbitration cycle.
- gnt is always one-hot or zero; gnt_id is held at the last owner while idle.

Optional Feature:
- Macro: COMMON_ARB_TIMEOUT_EN.
- Defined:
  - A hold counter clears on grant and increments each ARB_OWNED cycle.
  - When the owner has held gnt for MAX_HOLD cycles without release, gnt drops next cycle and state returns to ARB_IDLE.
  - timeout_err pulses 1 cycle, coincident with gnt falling.
  - Release in the same cycle as expiry counts as a normal release; no error pulse.
- Not defined: no counter, timeout_err tied 0, ownership unbounded.

Decomposition:
- common_pkg gains:
  - typedef enum bit {ARB_IDLE, ARB_OWNED} arb_state_e.
  - Constant ARB_MAX_N = 16.
  - Existing boolean type used for internal flags.
- One combinational sub-module, common_rr_picker:
  - Inputs: req vector and pointer.
  - Outputs: winner index and found flag.
  - Reusable by later schedulers.

Test Plan:
- Reset with N=4, req=4'b1111 → gnt=4'b0001 one cycle after rst_n release; gnt_id=0; busy=1.
- req=4'b1111 held, each owner pulses rel after 3 cycles → grant order 0,1,2,3,0 with one dead cycle between owners.
- Owner 2 holds, req[0] and req[3] assert → no change until owner 2 releases, then gnt=4'b1000 (3 beats 0 via rotation).
- rel[1] pulsed while owner is 2 → ignored. Owner 2 drops req[2] → gnt=0 next cycle.
- COMMON_ARB_TIMEOUT_EN with MAX_HOLD=8, owner never releases → gnt falls after exactly 8 owned cycles, timeout_err high one cycle. Repeat with rel at cycle 8 → no error.
- Assert rst_n=0 mid-ownership → gnt=0, busy=0 immediately. After reset, req=4'b0100 → gnt=4'b0100 one cycle later.

Source files
------------

// File: rtl/common_pkg.sv
/*------------------------------------------------------------------------------
 * Module   : common_pkg
 * Brief    : Shared types and constants for common_* blocks (arbiter state,
 *            boolean flag type, arbiter size limit).
 * Revision : 1.0 - initial release with round-robin arbiter support
 *----------------------------------------------------------------------------*/
`default_nettype none

package common_pkg;

    typedef logic bool_t;
    localparam bool_t TRUE  = 1'b1;
    localparam bool_t FALSE = 1'b0;

    localparam int ARB_MAX_N = 16;

    typedef enum bit {
        ARB_IDLE,
        ARB_OWNED
    } arb_state_e;

endpackage : common_pkg

`default_nettype wire

// File: rtl/common_rr_arbiter_if.sv
/*------------------------------------------------------------------------------
 * Module   : common_rr_arbiter_if
 * Brief    : Request/release/grant bundle between requesters and the arbiter.
 * Revision : 1.0 - initial release
 *----------------------------------------------------------------------------*/
`default_nettype none

interface common_rr_arbiter_if #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
);
    logic [N-1:0]   req;
    logic [N-1:0]   rel;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic           busy;
    logic           timeout_err;

    modport master (
        output req, rel,
        input  gnt, gnt_id, busy, timeout_err
    );

    modport slave (
        input  req, rel,
        output gnt, gnt_id, busy, timeout_err
    );
endinterface : common_rr_arbiter_if

`default_nettype wire

// File: rtl/common_rr_picker.sv
/*------------------------------------------------------------------------------
 * Module   : common_rr_picker
 * Brief    : Combinational round-robin pick: first set request bit searching
 *            upward from (ptr+1) mod N, wrapping.
 * Revision : 1.0 - initial release
 *----------------------------------------------------------------------------*/
`default_nettype none

module common_rr_picker
    import common_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  wire logic [N-1:0]   req,
    input  wire logic [IDW-1:0] ptr,
    output logic      [IDW-1:0] winner,
    output bool_t               found
);

    always_comb begin
        winner = '0;
        found  = FALSE;
        for (int i = 0; i < N; i++) begin
            if (!found && req[(int'(ptr) + 1 + i) % N]) begin
                winner = IDW'((int'(ptr) + 1 + i) % N);
                found  = TRUE;
            end
        end
    end

endmodule : common_rr_picker

`default_nettype wire

// File: rtl/common_rr_arbiter.sv
/*------------------------------------------------------------------------------
 * Module   : common_rr_arbiter
 * Brief    : Round-robin lock arbiter; a requester keeps the grant until it
 *            releases. Optional forced revoke via COMMON_ARB_TIMEOUT_EN.
 * Revision : 1.0 - initial release
 *----------------------------------------------------------------------------*/
`default_nettype none

module common_rr_arbiter
    import common_pkg::*;
#(
    parameter int N        = 4,
    parameter int IDW      = $clog2(N),
    parameter int MAX_HOLD = 64
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    common_rr_arbiter_if.slave bus
);

    if (N < 2 || N > ARB_MAX_N) begin : g_bad_n
        $error("common_rr_arbiter: N out of range");
    end
    if (MAX_HOLD < 2) begin : g_bad_max_hold
        $error("common_rr_arbiter: MAX_HOLD must be >= 2");
    end

    arb_state_e     r_state, w_state_nxt;
    logic [IDW-1:0] r_ptr, w_ptr_nxt;
    logic [N-1:0]   r_gnt, w_gnt_nxt;
    logic [IDW-1:0] r_gnt_id, w_gnt_id_nxt;
    bool_t          r_terr, w_terr_nxt;
    logic [IDW-1:0] w_winner;
    bool_t          w_found;
    bool_t          w_owner_done;
    bool_t          w_expire;

    common_rr_picker #(.N(N), .IDW(IDW)) u_picker (
        .req    (bus.req),
        .ptr    (r_ptr),
        .winner (w_winner),
        .found  (w_found)
    );

    // A dropped request from the owner is treated the same as an explicit release.
    assign w_owner_done = bus.rel[r_gnt_id] | ~bus.req[r_gnt_id];

`ifdef COMMON_ARB_TIMEOUT_EN
    localparam int CW = $clog2(MAX_HOLD);

    logic [CW-1:0] r_hold, w_hold_nxt;

    // Counts owned cycles minus one; reaching MAX_HOLD-1 means MAX_HOLD cycles held.
    assign w_hold_nxt = (r_state == ARB_IDLE) ? '0 : r_hold + 1'b1;
    assign w_expire   = (r_state == ARB_OWNED) && (r_hold == CW'(MAX_HOLD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold <= '0;
        end else begin
            r_hold <= w_hold_nxt;
        end
    end
`else
    assign w_expire = FALSE;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_ptr_nxt    = r_ptr;
        w_gnt_nxt    = r_gnt;
        w_gnt_id_nxt = r_gnt_id;
        w_terr_nxt   = FALSE;
        case (r_state)
            ARB_IDLE: begin
                if (w_found) begin
                    w_state_nxt  = ARB_OWNED;
                    w_gnt_nxt    = N'(1) << w_winner;
                    w_gnt_id_nxt = w_winner;
                    w_ptr_nxt    = w_winner;
                end
            end
            ARB_OWNED: begin
                if (w_owner_done) begin
                    w_state_nxt = ARB_IDLE;
                    w_gnt_nxt   = '0;
                end else if (w_expire) begin
                    w_state_nxt = ARB_IDLE;
                    w_gnt_nxt   = '0;
                    w_terr_nxt  = TRUE;
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ARB_IDLE;
            r_ptr    <= IDW'(N - 1);
            r_gnt    <= '0;
            r_gnt_id <= '0;
            r_terr   <= FALSE;
        end else begin
            r_state  <= w_state_nxt;
            r_ptr    <= w_ptr_nxt;
            r_gnt    <= w_gnt_nxt;
            r_gnt_id <= w_gnt_id_nxt;
            r_terr   <= w_terr_nxt;
        end
    end

    assign bus.gnt         = r_gnt;
    assign bus.gnt_id      = r_gnt_id;
    assign bus.busy        = |r_gnt;
    assign bus.timeout_err = r_terr;

endmodule : common_rr_arbiter

`default_nettype wire

// File: tb/tb_common_rr_arbiter.sv
/*------------------------------------------------------------------------------
 * Module   : tb_common_rr_arbiter
 * Brief    : Directed self-checking bench for common_rr_arbiter (N=4,
 *            MAX_HOLD=8; timeout steps active under COMMON_ARB_TIMEOUT_EN).
 * Revision : 1.0 - initial release
 *----------------------------------------------------------------------------*/
`default_nettype none

module tb_common_rr_arbiter;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    common_rr_arbiter_if #(.N(4)) bus ();

    common_rr_arbiter #(.N(4), .MAX_HOLD(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] eg, input logic [1:0] eid,
                       input logic eb, input logic et);
        checks++;
        assert ({bus.gnt, bus.gnt_id, bus.busy, bus.timeout_err} === {eg, eid, eb, et})
        else begin
            failures++;
            $error("FAIL %s: observed gnt=%b id=%0d busy=%b terr=%b, expected gnt=%b id=%0d busy=%b terr=%b",
                   tag, bus.gnt, bus.gnt_id, bus.busy, bus.timeout_err, eg, eid, eb, et);
        end
    endtask

    initial begin
        int order [5];
        order    = '{0, 1, 2, 3, 0};
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus.req  = 4'b0000;
        bus.rel  = 4'b0000;

        repeat (2) step();
        chk("reset", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Release reset with everyone requesting: requester 0 wins first.
        bus.req = 4'b1111;
        rst_n   = 1'b1;
        step();
        chk("first_grant", 4'b0001, 2'd0, 1'b1, 1'b0);

        // Each owner holds 3 cycles then pulses rel; one dead cycle between owners.
        for (int k = 0; k < 4; k++) begin
            step();
            step();
            chk("hold", 4'(1 << order[k]), 2'(order[k]), 1'b1, 1'b0);
            bus.rel = 4'(1 << order[k]);
            step();
            bus.rel = 4'b0000;
            chk("dead_cycle", 4'b0000, 2'(order[k]), 1'b0, 1'b0);
            step();
            chk("rotate", 4'(1 << order[k + 1]), 2'(order[k + 1]), 1'b1, 1'b0);
        end

        // Owner 0 drops req: implicit release, then 2 is the only requester.
        bus.req = 4'b0100;
        step();
        chk("implicit_rel0", 4'b0000, 2'd0, 1'b0, 1'b0);
        step();
        chk("grant2", 4'b0100, 2'd2, 1'b1, 1'b0);

        bus.req = 4'b1101;
        step();
        chk("others_req_no_effect", 4'b0100, 2'd2, 1'b1, 1'b0);
        bus.rel = 4'b0010;
        step();
        bus.rel = 4'b0000;
        chk("nonowner_rel_ignored", 4'b0100, 2'd2, 1'b1, 1'b0);
        bus.req = 4'b1001;
        step();
        chk("drop_req2", 4'b0000, 2'd2, 1'b0, 1'b0);
        step();
        chk("rotate_to_3", 4'b1000, 2'd3, 1'b1, 1'b0);

        // rel with req still high: release wins, 0 follows by rotation.
        bus.rel = 4'b1000;
        step();
        bus.rel = 4'b0000;
        chk("rel_wins", 4'b0000, 2'd3, 1'b0, 1'b0);
        step();
        chk("after_rel_wins", 4'b0001, 2'd0, 1'b1, 1'b0);

        // Lone requester may own back-to-back.
        bus.req = 4'b0001;
        bus.rel = 4'b0001;
        step();
        bus.rel = 4'b0000;
        chk("solo_rel", 4'b0000, 2'd0, 1'b0, 1'b0);
        step();
        chk("solo_regrant", 4'b0001, 2'd0, 1'b1, 1'b0);

`ifdef COMMON_ARB_TIMEOUT_EN
        for (int c = 2; c <= 8; c++) begin
            step();
            chk("to_hold", 4'b0001, 2'd0, 1'b1, 1'b0);
        end
        step();
        chk("timeout", 4'b0000, 2'd0, 1'b0, 1'b1);
        step();
        chk("to_regrant", 4'b0001, 2'd0, 1'b1, 1'b0);
        for (int c = 2; c <= 8; c++) begin
            step();
            chk("to_hold2", 4'b0001, 2'd0, 1'b1, 1'b0);
        end
        bus.rel = 4'b0001;
        step();
        bus.rel = 4'b0000;
        chk("rel_at_expiry", 4'b0000, 2'd0, 1'b0, 1'b0);
        step();
        chk("regrant_after_rel", 4'b0001, 2'd0, 1'b1, 1'b0);
`else
        for (int c = 0; c < 20; c++) begin
            step();
            chk("no_timeout", 4'b0001, 2'd0, 1'b1, 1'b0);
        end
`endif

        // Asynchronous reset mid-ownership.
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        bus.req = 4'b0100;
        step();
        chk("post_reset_grant", 4'b0100, 2'd2, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_common_rr_arbiter

`default_nettype wire
